// File: rtl/romram_pkg.sv
// Shared definitions for the ROM/RAM checksum sequencer: default widths,
// sequencing constants and the FSM state encoding.
package romram_pkg;

  localparam int DEF_DW       = 16;
  localparam int DEF_ROM_AW   = 4;
  localparam int DEF_RAM_AW   = 2;
  localparam int DEF_SUM_LEN  = 15;
  localparam int DEF_ACC_SLOT = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    ACC  = 3'd2,
    WR   = 3'd3,
    CMP  = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/romram_seq.sv
// Sequencer that clears a RAM accumulator slot, sums ROM[0..SUM_LEN-1] into it
// by read-modify-write, and compares the result with the checksum at ROM[SUM_LEN].
module romram_seq #(
  parameter int DW       = romram_pkg::DEF_DW,
  parameter int ROM_AW   = romram_pkg::DEF_ROM_AW,
  parameter int RAM_AW   = romram_pkg::DEF_RAM_AW,
  parameter int SUM_LEN  = romram_pkg::DEF_SUM_LEN,
  parameter int ACC_SLOT = romram_pkg::DEF_ACC_SLOT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_cs,
  input  logic [DW-1:0]     rom_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_rw,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     sum,
  output logic              match,
  output logic              ovf,
  output logic [2:0]        dbg_state
);
  import romram_pkg::*;

  // Handshake: start is sampled only in IDLE; busy is high from the accepting
  // edge until the edge that raises done; done is sticky until the next accept.

  localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(SUM_LEN - 1);
  localparam logic [ROM_AW-1:0] CHK_ADDR = ROM_AW'(SUM_LEN);
  localparam logic [RAM_AW-1:0] SLOT     = RAM_AW'(ACC_SLOT);

  state_t            state_q, state_d;
  logic [ROM_AW-1:0] idx_q, idx_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     sum_q, sum_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              match_q, match_d;
  logic              ovf_q, ovf_d;
  logic [DW:0]       add_full;

  assign add_full = {1'b0, rom_data} + {1'b0, ram_dout};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    sum_d   = sum_q;
    busy_d  = busy_q;
    done_d  = done_q;
    match_d = match_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          match_d = 1'b0;
          ovf_d   = 1'b0;
          sum_d   = '0;
          idx_d   = '0;
        end
      end
      CLR: state_d = ACC;
      ACC: begin
        wdata_d = add_full[DW-1:0];
        if (add_full[DW]) ovf_d = 1'b1;
        state_d = WR;
      end
      WR: begin
        if (idx_q == LAST_IDX) begin
          state_d = CMP;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ACC;
        end
      end
      CMP: begin
        sum_d   = ram_dout;
        match_d = (ram_dout == rom_data);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes are decoded from registered state only, so they are glitch-free.
  always_comb begin
    rom_cs   = 1'b0;
    rom_addr = '0;
    ram_cs   = 1'b0;
    ram_rw   = 1'b0;
    ram_din  = '0;
    case (state_q)
      CLR: begin
        ram_cs = 1'b1;
        ram_rw = 1'b1;
      end
      ACC: begin
        rom_cs   = 1'b1;
        rom_addr = idx_q;
        ram_cs   = 1'b1;
      end
      WR: begin
        ram_cs  = 1'b1;
        ram_rw  = 1'b1;
        ram_din = wdata_q;
      end
      CMP: begin
        rom_cs   = 1'b1;
        rom_addr = CHK_ADDR;
        ram_cs   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ram_addr  = SLOT;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign match     = match_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_romram_seq.sv
// Bench for romram_seq: behavioural 16x16 ROM and 4x16 RAM around the sequencer,
// directed and randomized runs checked against a plain arithmetic checksum model.
module tb_romram_seq;

  localparam int SUM_LEN = 15;
  localparam int LAT     = 2 * SUM_LEN + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  rom_addr;
  logic        rom_cs;
  logic [15:0] rom_data;
  logic [1:0]  ram_addr;
  logic        ram_cs;
  logic        ram_rw;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        busy, done, match, ovf;
  logic [15:0] sum;
  logic [2:0]  dbg_state;

  logic [15:0] rom [16];
  logic [15:0] ram [4];
  logic        ld_en = 1'b0;
  logic [1:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  int          wr_cnt = 0;
  int          bad_wr = 0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  romram_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_rw(ram_rw),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .done(done), .sum(sum), .match(match), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  assign rom_data = rom[rom_addr];
  assign ram_dout = ram[ram_addr];

  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (ram_cs && ram_rw) ram[ram_addr] <= ram_din;
  end

  always @(posedge clk) begin
    if (ram_cs && ram_rw) begin
      wr_cnt <= wr_cnt + 1;
      if (ram_addr != 2'd1) bad_wr <= bad_wr + 1;
    end
  end

  // Reference: plain modular sum with a sticky carry flag, then the checksum compare.
  function automatic void model(output logic [15:0] s, output logic o, output logic m);
    int acc;
    acc = 0;
    o = 1'b0;
    for (int k = 0; k < SUM_LEN; k++) begin
      acc = acc + int'(rom[k]);
      if (acc > 16'hFFFF) begin
        o = 1'b1;
        acc = acc - 65536;
      end
    end
    s = acc[15:0];
    m = (s == rom[SUM_LEN]);
  endfunction

  task automatic load_ram(input logic [1:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic fill_ram_random();
    for (int k = 0; k < 4; k++) load_ram(k[1:0], 16'($urandom));
  endtask

  task automatic rom_ramp(input logic [15:0] chk);
    for (int k = 0; k < SUM_LEN; k++) rom[k] = 16'(k);
    rom[SUM_LEN] = chk;
  endtask

  // Pulse start and count edges until done; optionally re-pulse start mid-run.
  task automatic do_run(input bit repulse, output int cycles, output int writes, output logic busy0);
    int w0;
    w0 = wr_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy;
    cycles = 0;
    while (!done && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (repulse) start = (cycles == 5 || cycles == 20);
    end
    start = 1'b0;
    writes = wr_cnt - w0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, match, ovf, rom_cs, ram_cs, ram_rw} !== 7'b0 || sum !== 16'h0 || rom_addr !== 4'h0 || ram_din !== 16'h0)
      $display("FAIL reset: busy=%b done=%b match=%b ovf=%b rom_cs=%b ram_cs=%b ram_rw=%b sum=%h rom_addr=%h ram_din=%h, expected all 0",
               busy, done, match, ovf, rom_cs, ram_cs, ram_rw, sum, rom_addr, ram_din);
    else pass_cnt++;
    total_cnt++;
    if (ram_addr !== 2'd1) $display("FAIL reset_ram_addr: got %0d expected 1", ram_addr);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input string name, input bit repulse);
    int cyc, wr;
    logic b0, eo, em;
    logic [15:0] es, r0, r2, r3;
    model(es, eo, em);
    r0 = ram[0]; r2 = ram[2]; r3 = ram[3];
    do_run(repulse, cyc, wr, b0);
    total_cnt++;
    if (b0 !== 1'b1) $display("FAIL %s busy_rise: got %b expected 1", name, b0);
    else pass_cnt++;
    total_cnt++;
    if (cyc !== LAT) $display("FAIL %s latency: got %0d expected %0d", name, cyc, LAT);
    else pass_cnt++;
    total_cnt++;
    if (sum !== es || match !== em || ovf !== eo || done !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s result: sum=%h match=%b ovf=%b done=%b busy=%b expected sum=%h match=%b ovf=%b done=1 busy=0",
               name, sum, match, ovf, done, busy, es, em, eo);
    else pass_cnt++;
    total_cnt++;
    if (ram[1] !== es || ram[0] !== r0 || ram[2] !== r2 || ram[3] !== r3)
      $display("FAIL %s ram: slot1=%h others=%h/%h/%h expected %h and %h/%h/%h", name, ram[1], ram[0], ram[2], ram[3], es, r0, r2, r3);
    else pass_cnt++;
    total_cnt++;
    if (wr !== SUM_LEN + 1 || bad_wr !== 0) $display("FAIL %s writes: got %0d (bad addr %0d) expected %0d", name, wr, bad_wr, SUM_LEN + 1);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (done !== 1'b1 || sum !== es || match !== em || ovf !== eo)
      $display("FAIL %s hold: done=%b sum=%h match=%b ovf=%b expected done=1 sum=%h match=%b ovf=%b", name, done, sum, match, ovf, es, em, eo);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total_cnt++;
    if (ram[1] !== 16'd6) $display("FAIL midrun_partial: got %h expected 0006", ram[1]);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, done, match, ovf, rom_cs, ram_cs, ram_rw} !== 7'b0 || sum !== 16'h0)
      $display("FAIL midrun_reset: busy=%b done=%b match=%b ovf=%b rom_cs=%b ram_cs=%b ram_rw=%b sum=%h expected all 0",
               busy, done, match, ovf, rom_cs, ram_cs, ram_rw, sum);
    else pass_cnt++;
    rst = 1'b0;
    cyc = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy) cyc++;
    end
    total_cnt++;
    if (cyc !== 0) $display("FAIL midrun_stays_idle: busy seen %0d cycles expected 0", cyc);
    else pass_cnt++;
    test_basic("after_reset", 1'b0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic b0;
    start = 1'b1;
    @(posedge clk); #1;
    b0 = busy;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    total_cnt++;
    if (b0 !== 1'b1 || cyc !== LAT) $display("FAIL b2b_first: busy0=%b latency=%0d expected 1/%0d", b0, cyc, LAT);
    else pass_cnt++;
    cyc = 0;
    while (!busy && cyc < 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    total_cnt++;
    if (busy !== 1'b1 || done !== 1'b0 || cyc < 1 || cyc > 3)
      $display("FAIL b2b_restart: busy=%b done=%b after %0d edges expected busy=1 done=0 within 3", busy, done, cyc);
    else pass_cnt++;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    total_cnt++;
    if (cyc !== LAT || sum !== 16'h0069 || match !== 1'b1 || ram[1] !== 16'h0069)
      $display("FAIL b2b_second: latency=%0d sum=%h match=%b slot=%h expected %0d/0069/1/0069", cyc, sum, match, ram[1], LAT);
    else pass_cnt++;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [15:0] es;
      logic eo, em;
      for (int k = 0; k < SUM_LEN; k++)
        rom[k] = (t < 4) ? 16'($urandom_range(0, 300)) : 16'($urandom);
      model(es, eo, em);
      rom[SUM_LEN] = ($urandom_range(0, 1) == 1) ? es : 16'($urandom);
      fill_ram_random();
      test_basic("random", 1'b0);
    end
  endtask

  initial begin
    start = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) ram[k] = '0;
    rom_ramp(16'h0069);
    test_reset();
    fill_ram_random();
    test_basic("ramp_match", 1'b0);
    rom_ramp(16'h0070);
    test_basic("ramp_nomatch", 1'b0);
    for (int k = 0; k < SUM_LEN; k++) rom[k] = 16'hFFFF;
    rom[SUM_LEN] = 16'hFFF1;
    test_basic("all_ones_ovf", 1'b0);
    total_cnt++;
    if (sum !== 16'hFFF1 || ovf !== 1'b1) $display("FAIL ovf_const: sum=%h ovf=%b expected FFF1/1", sum, ovf);
    else pass_cnt++;
    rom_ramp(16'h0069);
    test_basic("start_while_busy", 1'b1);
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
